// File: rtl/pc_register_pkg.sv
// pc_register_pkg: shared CPU constants used by the program-counter register
package pc_register_pkg;
    localparam int unsigned XLEN         = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned INSN_BYTES   = 4;
endpackage

// File: rtl/pc_register.sv
// pc_register: program counter with async reset, load enable and a precomputed sequential address
module pc_register
    import pc_register_pkg::*;
#(
    parameter int unsigned       WIDTH        = XLEN,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = pc_register_pkg::RESET_VECTOR
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PC_EN,
    input  logic [WIDTH-1:0] PC_NEXT,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC_PLUS4
);
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    // load the next PC when enabled, otherwise stall on the current value
    always_comb pc_d = PC_EN ? PC_NEXT : pc_q;

    // PC flop; reset forces the vector immediately, independent of the clock
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) pc_q <= RESET_VECTOR;
        else     pc_q <= pc_d;
    end

    assign PC       = pc_q;
    assign PC_PLUS4 = pc_q + WIDTH'(INSN_BYTES);
endmodule

// File: tb/tb_pc_register.sv
// tb_pc_register: directed and randomized checks of pc_register against a simple reference model
module tb_pc_register;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        PC_EN = 1'b0;
    logic [31:0] PC_NEXT = '0;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] model_pc;

    pc_register dut (
        .CLK(CLK), .RST(RST), .PC_EN(PC_EN), .PC_NEXT(PC_NEXT),
        .PC(PC), .PC_PLUS4(PC_PLUS4)
    );

    always #5 CLK = ~CLK;

    task automatic edge_step();
        @(posedge CLK);
        if (!RST && PC_EN) model_pc = PC_NEXT;
        #1;
    endtask

    task automatic check(input string name);
        n_cmp++;
        if (PC !== model_pc) begin
            n_err++;
            $display("FAIL %s: PC got %h expected %h", name, PC, model_pc);
        end
        n_cmp++;
        if (PC_PLUS4 !== model_pc + 32'd4) begin
            n_err++;
            $display("FAIL %s: PC_PLUS4 got %h expected %h", name, PC_PLUS4, model_pc + 32'd4);
        end
    endtask

    task automatic test_reset();
        #1;
        RST = 1'b1; PC_EN = 1'b0; PC_NEXT = '0;
        model_pc = 32'h0;
        #1;
        n_cmp++;
        if (PC !== 32'h0) begin
            n_err++;
            $display("FAIL reset_async: PC got %h expected %h", PC, 32'h0);
        end
        edge_step();
        n_cmp++;
        if (PC !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL reset_edge: PC got %h expected %h", PC, 32'h0);
        end
        n_cmp++;
        if (PC_PLUS4 !== 32'h0000_0004) begin
            n_err++;
            $display("FAIL reset_plus4: PC_PLUS4 got %h expected %h", PC_PLUS4, 32'h4);
        end
    endtask

    task automatic test_load();
        RST = 1'b0; PC_EN = 1'b1; PC_NEXT = 32'h0000_0004;
        edge_step();
        n_cmp++;
        if (PC !== 32'h0000_0004) begin
            n_err++;
            $display("FAIL load_4: PC got %h expected %h", PC, 32'h4);
        end
        PC_NEXT = 32'h0000_0008;
        edge_step();
        n_cmp++;
        if (PC !== 32'h0000_0008) begin
            n_err++;
            $display("FAIL load_8: PC got %h expected %h", PC, 32'h8);
        end
    endtask

    task automatic test_stall();
        PC_EN = 1'b0; PC_NEXT = 32'hDEAD_BEEF;
        edge_step();
        n_cmp++;
        if (PC !== 32'h0000_0008) begin
            n_err++;
            $display("FAIL stall: PC got %h expected %h", PC, 32'h8);
        end
    endtask

    task automatic test_resume();
        PC_EN = 1'b1; PC_NEXT = 32'h1000_0000;
        edge_step();
        n_cmp++;
        if (PC !== 32'h1000_0000) begin
            n_err++;
            $display("FAIL resume: PC got %h expected %h", PC, 32'h1000_0000);
        end
        n_cmp++;
        if (PC_PLUS4 !== 32'h1000_0004) begin
            n_err++;
            $display("FAIL resume_plus4: PC_PLUS4 got %h expected %h", PC_PLUS4, 32'h1000_0004);
        end
    endtask

    task automatic test_reset_mid();
        PC_EN = 1'b1; PC_NEXT = 32'h2000_0000;
        @(negedge CLK);
        RST = 1'b1;
        model_pc = 32'h0;
        #1;
        n_cmp++;
        if (PC !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_async: PC got %h expected %h", PC, 32'h0);
        end
        edge_step();
        n_cmp++;
        if (PC !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_edge: PC got %h expected %h", PC, 32'h0);
        end
        RST = 1'b0;
    endtask

    task automatic test_wrap_unaligned();
        PC_EN = 1'b1; PC_NEXT = 32'hFFFF_FFFC;
        edge_step();
        n_cmp++;
        if (PC_PLUS4 !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL wrap_plus4: PC_PLUS4 got %h expected %h", PC_PLUS4, 32'h0);
        end
        PC_NEXT = 32'h0000_0003;
        edge_step();
        n_cmp++;
        if (PC !== 32'h0000_0003) begin
            n_err++;
            $display("FAIL unaligned: PC got %h expected %h", PC, 32'h3);
        end
        n_cmp++;
        if (PC_PLUS4 !== 32'h0000_0007) begin
            n_err++;
            $display("FAIL unaligned_plus4: PC_PLUS4 got %h expected %h", PC_PLUS4, 32'h7);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            PC_EN   = 1'($urandom_range(0, 1));
            PC_NEXT = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC - 32'($urandom_range(0, 3)) : 32'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                RST = 1'b1;
                model_pc = 32'h0;
                #1;
                check("rand_async_reset");
            end
            edge_step();
            check("rand_cycle");
            RST = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            PC_EN   = ~PC_EN;
            PC_NEXT = model_pc + 32'h100;
            edge_step();
            check("toggle_en");
        end
    endtask

    initial begin
        model_pc = '0;
        test_reset();
        test_load();
        test_stall();
        test_resume();
        test_reset_mid();
        test_wrap_unaligned();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
